// File: rtl/ex_muldiv_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
package muldiv_pkg;

    // Operation codes carried on the op field from ID/EX; 6 and 7 are reserved.
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;

    // Controller states: idle, iterating multiply, iterating divide, final write.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } muldiv_state_t;

    // Number of iteration cycles for a 32-bit operation (one bit per cycle).
    localparam int MULDIV_ITERS = 32;

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // EX stage side: issues operations and reads HI/LO.
    modport master (
        output flush, start, op, a, b,
        input  busy, done, hi, lo
    );

    // Unit side: accepts operations and owns HI/LO.
    modport slave (
        input  flush, start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative MIPS multiply/divide unit: shift-add multiply and restoring
// divide at one bit per cycle, plus single-cycle MTHI/MTLO. Owns HI/LO.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    ex_muldiv_if.slave bus
);

    // Conditional two's-complement negation helpers for the final fix-up.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    muldiv_state_t state, state_nxt;

    logic [5:0]         count;
    logic               is_signed;
    logic               is_div;
    logic               sign_a;
    logic               sign_b;
    logic               div_zero;
    logic [WIDTH-1:0]   orig_a;
    logic [WIDTH-1:0]   opb;      // |b|: multiplicand or divisor
    logic [2*WIDTH-1:0] acc;      // multiply accumulator, multiplier in low half
    logic [WIDTH-1:0]   rem;      // divide partial remainder
    logic [WIDTH-1:0]   quo;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic               start_mul;
    logic               start_div;
    logic               write_hi;
    logic               write_lo;
    logic               fix_write;
    logic               signed_op;
    logic               iterate;
    logic               last_iter;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign mag_a     = cond_neg(bus.a, signed_op && bus.a[WIDTH-1]);
    assign mag_b     = cond_neg(bus.b, signed_op && bus.b[WIDTH-1]);
    assign iterate   = (state == MUL) || (state == DIV);
    assign last_iter = (count == 6'(WIDTH - 1));

    // One multiply step: conditionally add |b| into the upper half, shift right.
    assign mul_sum = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb})
                            : {1'b0, acc[2*WIDTH-1:WIDTH]};
    assign acc_nxt = {mul_sum, acc[WIDTH-1:1]};

    // One restoring-divide step: a set top bit of the trial means it went negative.
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opb};
    assign rem_nxt   = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
    assign quo_nxt   = {quo[WIDTH-2:0], ~div_trial[WIDTH]};

    // Sign fix-up and divide-by-zero override for the final HI/LO write.
    always_comb begin
        prod_fix = cond_neg2(acc, is_signed && (sign_a ^ sign_b));
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                fix_hi = orig_a;
                fix_lo = '1;
            end else begin
                fix_hi = cond_neg(rem, is_signed && sign_a);
                fix_lo = cond_neg(quo, is_signed && (sign_a ^ sign_b));
            end
        end
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode and single-cycle strobes; flush overrides everything.
    always_comb begin
        // NOTE: every output gets a default first so no path holds a value and no latch is inferred.
        state_nxt = state;
        start_mul = 1'b0;
        start_div = 1'b0;
        write_hi  = 1'b0;
        write_lo  = 1'b0;
        fix_write = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            start_mul = 1'b1;
                            state_nxt = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            start_div = 1'b1;
                            state_nxt = DIV;
                        end
                        OP_MTHI: write_hi = 1'b1;
                        OP_MTLO: write_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            MUL: if (last_iter) state_nxt = FIX;
            DIV: if (last_iter) state_nxt = FIX;
            FIX: begin
                fix_write = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) begin
            state_nxt = IDLE;
            start_mul = 1'b0;
            start_div = 1'b0;
            write_hi  = 1'b0;
            write_lo  = 1'b0;
            fix_write = 1'b0;
        end
    end

    // Operand latch, iteration datapath, and HI/LO architectural registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: datapath registers are reset too, so a mid-operation reset leaves no stale operands.
            count     <= '0;
            is_signed <= 1'b0;
            is_div    <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            div_zero  <= 1'b0;
            orig_a    <= '0;
            opb       <= '0;
            acc       <= '0;
            rem       <= '0;
            quo       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= fix_write;
            if (start_mul || start_div) begin
                count     <= '0;
                is_signed <= signed_op;
                is_div    <= start_div;
                sign_a    <= bus.a[WIDTH-1];
                sign_b    <= bus.b[WIDTH-1];
                div_zero  <= (bus.b == '0);
                orig_a    <= bus.a;
                opb       <= mag_b;
                acc       <= {{WIDTH{1'b0}}, mag_a};
                quo       <= mag_a;
                rem       <= '0;
            end
            if (iterate) begin
                count <= count + 6'd1;
                if (state == MUL) begin
                    acc <= acc_nxt;
                end else begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                end
            end
            if (bus.flush) count <= '0;
            if (fix_write) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end
            if (write_hi) hi_q <= bus.a;
            if (write_lo) lo_q <= bus.a;
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
